// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg
// Shared definitions for the ALU sequencer: datapath sizes, command kinds,
// FSM states, 74181 function codes (f[4:1] = S3..S0, f[0] = M) and the
// shift-direction encoding carried on f[0] during shifts.
package alu_sequencer_pkg;

   localparam int WIDTH = 16;
   localparam int SHW   = 4;

   typedef enum logic [1:0] {
      K_ALU_UCIN = 2'b00,
      K_ALU_FCIN = 2'b01,
      K_SHIFT    = 2'b10,
      K_RSVD     = 2'b11
   } kind_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_EXEC  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   // Arithmetic mode (M=0)
   localparam logic [4:0] F_ADD   = {4'b1001, 1'b0};
   localparam logic [4:0] F_SUB   = {4'b0110, 1'b0};
   // Logic mode (M=1)
   localparam logic [4:0] F_AND   = {4'b1011, 1'b1};
   localparam logic [4:0] F_OR    = {4'b1110, 1'b1};
   localparam logic [4:0] F_XOR   = {4'b0110, 1'b1};
   localparam logic [4:0] F_PASSA = {4'b1111, 1'b1};

   localparam logic SH_LEFT  = 1'b1;
   localparam logic SH_RIGHT = 1'b0;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
// Bundles the command side (CPU control unit) and the ALU side of the
// sequencer. slave  = the sequencer's view.
//                master = the environment's view (control unit + ALU).
// Command: start, kind, cmdF, cmdUcin, opA, opB, shamt in;
//          result, carryFlag, zeroFlag, busy, done out.
// ALU:     aluA, aluB, aluF, aluCsel, aluUcin, aluFcin, aluNotALUOE,
//          aluNotShiftOE out; aluY, aluCout, aluZout in.
interface alu_sequencer_if;
   import alu_sequencer_pkg::*;

   logic             start;
   logic [1:0]       kind;
   logic [4:0]       cmdF;
   logic             cmdUcin;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] result;
   logic             carryFlag;
   logic             zeroFlag;
   logic             busy;
   logic             done;

   logic [WIDTH-1:0] aluA;
   logic [WIDTH-1:0] aluB;
   logic [4:0]       aluF;
   logic             aluCsel;
   logic             aluUcin;
   logic             aluFcin;
   logic             aluNotALUOE;
   logic             aluNotShiftOE;
   logic [WIDTH-1:0] aluY;
   logic             aluCout;
   logic             aluZout;

   modport slave (
      input  start, kind, cmdF, cmdUcin, opA, opB, shamt,
      input  aluY, aluCout, aluZout,
      output result, carryFlag, zeroFlag, busy, done,
      output aluA, aluB, aluF, aluCsel, aluUcin, aluFcin, aluNotALUOE, aluNotShiftOE
   );

   modport master (
      output start, kind, cmdF, cmdUcin, opA, opB, shamt,
      output aluY, aluCout, aluZout,
      input  result, carryFlag, zeroFlag, busy, done,
      input  aluA, aluB, aluF, aluCsel, aluUcin, aluFcin, aluNotALUOE, aluNotShiftOE
   );

endinterface

// File: rtl/alu_seq_fsm.sv
// alu_seq_fsm
// Sequencer state machine: state, shift iteration count and the registered
// ALU control lines (f, csel, ucin, both output enables) plus busy/done.
// Ports: clock, notReset; start/kind/cmd_f/cmd_ucin/shamt from the command
// bus; state to the datapath; registered control outputs to the ALU.
module alu_seq_fsm
   import alu_sequencer_pkg::*;
(
   input  logic           clock,
   input  logic           notReset,
   input  logic           start,
   input  logic [1:0]     kind,
   input  logic [4:0]     cmd_f,
   input  logic           cmd_ucin,
   input  logic [SHW-1:0] shamt,
   output state_e         state,
   output logic           busy,
   output logic           done,
   output logic           not_alu_oe,
   output logic           not_shift_oe,
   output logic [4:0]     alu_f,
   output logic           alu_csel,
   output logic           alu_ucin
);

   state_e         state_q, state_d;
   logic [SHW-1:0] count_q, count_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           not_alu_oe_q, not_alu_oe_d;
   logic           not_shift_oe_q, not_shift_oe_d;
   logic [4:0]     alu_f_q, alu_f_d;
   logic           alu_csel_q, alu_csel_d;
   logic           alu_ucin_q, alu_ucin_d;

   // Control lines are computed from the next state so they are valid for
   // the whole EXEC/SHIFT cycle; both enables default high, which keeps the
   // two bus drivers mutually exclusive by construction.
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      not_alu_oe_d   = 1'b1;
      not_shift_oe_d = 1'b1;
      alu_f_d        = alu_f_q;
      alu_csel_d     = alu_csel_q;
      alu_ucin_d     = alu_ucin_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               unique case (kind_e'(kind))
                  K_ALU_UCIN, K_ALU_FCIN: begin
                     state_d      = ST_EXEC;
                     not_alu_oe_d = 1'b0;
                     alu_f_d      = cmd_f;
                     alu_csel_d   = kind[0];
                     alu_ucin_d   = cmd_ucin;
                  end
                  K_SHIFT: begin
                     if (shamt != '0) begin
                        state_d        = ST_SHIFT;
                        count_d        = shamt;
                        not_shift_oe_d = 1'b0;
                        alu_f_d        = {4'b0000, cmd_f[0]};
                     end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                     end
                  end
                  default: begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                  end
               endcase
            end
         end
         ST_EXEC: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         ST_SHIFT: begin
            count_d = count_q - SHW'(1);
            if (count_q == SHW'(1)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               not_shift_oe_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;   // ST_DONE: start is ignored here
      endcase
   end

   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         state_q        <= ST_IDLE;
         count_q        <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         not_alu_oe_q   <= 1'b1;
         not_shift_oe_q <= 1'b1;
         alu_f_q        <= '0;
         alu_csel_q     <= 1'b0;
         alu_ucin_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         not_alu_oe_q   <= not_alu_oe_d;
         not_shift_oe_q <= not_shift_oe_d;
         alu_f_q        <= alu_f_d;
         alu_csel_q     <= alu_csel_d;
         alu_ucin_q     <= alu_ucin_d;
      end
   end

   assign state        = state_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign not_alu_oe   = not_alu_oe_q;
   assign not_shift_oe = not_shift_oe_q;
   assign alu_f        = alu_f_q;
   assign alu_csel     = alu_csel_q;
   assign alu_ucin     = alu_ucin_q;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Control block in front of the 16-bit 74181 ALU. Accepts one command at a
// time, drives the ALU controls and captures y/cout/zout into the result
// and flag registers. Multi-bit shifts loop y back into A once per cycle.
// Ports: clock, notReset (async, active low); bus = alu_sequencer_if.slave
// carrying the command handshake and the ALU control/result lines.
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic            clock,
   input  logic            notReset,
   alu_sequencer_if.slave  bus
);

   state_e           state;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;

   alu_seq_fsm u_fsm (
      .clock        (clock),
      .notReset     (notReset),
      .start        (bus.start),
      .kind         (bus.kind),
      .cmd_f        (bus.cmdF),
      .cmd_ucin     (bus.cmdUcin),
      .shamt        (bus.shamt),
      .state        (state),
      .busy         (bus.busy),
      .done         (bus.done),
      .not_alu_oe   (bus.aluNotALUOE),
      .not_shift_oe (bus.aluNotShiftOE),
      .alu_f        (bus.aluF),
      .alu_csel     (bus.aluCsel),
      .alu_ucin     (bus.aluUcin)
   );

   // aluY is only looked at in EXEC/SHIFT; elsewhere the bus floats.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      unique case (state)
         ST_IDLE: begin
            // Reserved kind leaves every register untouched.
            if (bus.start && kind_e'(bus.kind) != K_RSVD) begin
               a_d = bus.opA;
               b_d = bus.opB;
               // Zero-length shift completes immediately: result is A,
               // carry keeps its old value.
               if (kind_e'(bus.kind) == K_SHIFT && bus.shamt == '0) begin
                  result_d = bus.opA;
                  zero_d   = (bus.opA == '0);
               end
            end
         end
         ST_EXEC: begin
            result_d = bus.aluY;
            carry_d  = bus.aluCout;
            zero_d   = bus.aluZout;
         end
         ST_SHIFT: begin
            a_d      = bus.aluY;
            result_d = bus.aluY;
            carry_d  = bus.aluCout;
            zero_d   = bus.aluZout;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.aluA      = a_q;
   assign bus.aluB      = b_q;
   assign bus.result    = result_q;
   assign bus.carryFlag = carry_q;
   assign bus.zeroFlag  = zero_q;
   // Registered carry feeds the ALU so kind 01 chains across commands.
   assign bus.aluFcin   = carry_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control block in front of the 16-bit ALU (four 74181 slices with shift buffers). It accepts one command at a time and drives the ALU control lines (f, csel, ucin, notALUOE, notShiftOE). It captures y/cout/zout into result and flag registers. Multi-bit shifts are iterated through the ALU's single-bit shift path, feeding the result back as the A operand each cycle. The block sits between the CPU control unit and the ALU and owns the carry/zero flag registers that feed the ALU fcin input.

Parameters:
WIDTH, 16, datapath width; only 16 is supported.
SHW, 4, width of the shift-amount field.

Ports:
clock  input  1  system clock, rising edge
notReset  input  1  asynchronous, active-low reset
start  input  1  command request, sampled only when busy=0
kind  input  2  00=ALU op with ucin, 01=ALU op with flag carry, 10=shift, 11=reserved
cmdF  input  5  ALU function; f[4:1]=74181 S3..S0, f[0]=M; for shifts f[0] is direction, 1=left, 0=right
cmdUcin  input  1  user carry-in for kind 00
opA  input  16  operand A
opB  input  16  operand B
shamt  input  4  shift count 0..15, kind 10 only
aluA  output  16  to ALU a
aluB  output  16  to ALU b
aluF  output  5  to ALU f
aluCsel  output  1  to ALU csel; 0 selects ucin, 1 selects fcin
aluUcin  output  1  to ALU ucin
aluFcin  output  1  to ALU fcin; always equals carryFlag
aluNotALUOE  output  1  ALU output-buffer enable, active low
aluNotShiftOE  output  1  shift-buffer enable, active low
aluY  input  16  ALU result bus
aluCout  input  1  ALU carry out
aluZout  input  1  ALU zero out
result  output  16  captured result
carryFlag  output  1  carry flag register
zeroFlag  output  1  zero flag register
busy  output  1  command in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous while notReset=0:
  - state=IDLE.
  - result=0, carryFlag=0, zeroFlag=0, busy=0, done=0.
  - aluNotALUOE=1, aluNotShiftOE=1, aluF=0, aluCsel=0, aluUcin=0, aluA=0, aluB=0.
- Reset asserted mid-command aborts the command; no partial result or flags survive.
- Bus rule: aluNotALUOE and aluNotShiftOE are never both 0. Both are 1 in IDLE and DONE. The bus therefore floats outside EXEC/SHIFT, and aluY is ignored there.
- All outputs are registered; no combinational path from start to the ALU controls.
- States: IDLE, EXEC, SHIFT, DONE.
- IDLE:
  - On start=1, latch kind, cmdF, cmdUcin, opA, opB and shamt, and set busy=1.
  - kind 00/01 -> EXEC.
  - kind 10 with shamt!=0 -> SHIFT, count=shamt.
  - kind 10 with shamt=0 -> DONE. result=opA, zeroFlag=(opA==0), carryFlag unchanged.
  - kind 11 -> DONE with no register change.
- EXEC, one cycle:
  - Drive aluNotALUOE=0, aluF=cmdF, aluCsel=kind[0], aluUcin=cmdUcin.
  - At the cycle end, capture result=aluY, carryFlag=aluCout, zeroFlag=aluZout. -> DONE.
- SHIFT:
  - Drive aluNotShiftOE=0, aluF[0]=direction, aluA=current A; the other aluF bits are don't-care and held at 0.
  - Each cycle: A<=aluY, result<=aluY, carryFlag<=aluCout, zeroFlag<=aluZout, count<=count-1.
  - When count reaches 1 (last iteration), -> DONE.
  - A shift by n takes exactly n SHIFT cycles. carryFlag ends as the last bit shifted out.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, -> IDLE.
- busy timing: busy=1 from the cycle after start is accepted until DONE.
- start while busy=1 is ignored, with no queueing.
- A start in the same cycle as done is ignored; a new command can be accepted no earlier than the cycle after done.
- Latency from start sampled to the done pulse:
  - ALU op: 2 cycles.
  - Shift by n: n+1 cycles.
  - shamt=0 or reserved kind: 1 cycle.
- aluFcin always reflects the registered carryFlag, so kind 01 chains carries across commands (multi-word add/subtract).

Decomposition:
- Shared package/include alu_defs.v holds:
  - the kind encodings;
  - state encodings;
  - 74181 function constants: F_ADD (S=1001, M=0), F_SUB (S=0110, M=0), F_AND, F_OR, F_XOR, F_PASSA;
  - shift-direction constants SH_LEFT=1, SH_RIGHT=0.
- One sub-module, alu_seq_fsm: state register, count and next-state/output decode.
- The top level holds the operand/result/flag registers and the ALU port wiring.
- The bench instantiates alu_sequencer together with the existing structural alu.

Test Plan:
- Reset mid-shift (kind 10, shamt=8, notReset low in the 3rd SHIFT cycle) -> all outputs at reset values immediately, both OE high, busy=0; next command executes normally.
- ADD kind 00, opA=0xFFFF, opB=0x0001, ucin=0 -> done 2 cycles after start; result=0x0000, carryFlag=1, zeroFlag=1; only aluNotALUOE=0 during EXEC.
- Carry chain: ADD 0xFFFF+0x0001 kind 00, then ADD kind 01 with 0x0000+0x0000 -> second result=0x0001, carryFlag=0, zeroFlag=0.
- Shift left kind 10, opA=0x8001, shamt=4 -> 4 SHIFT cycles, done at cycle 5; result=0x0010, carryFlag=0 (last bit out is bit 12 of the original A = 0), zeroFlag=0.
- Shift right opA=0x0003, shamt=1 -> result=0x0001, carryFlag=1.
- Shift opA=0x0000, shamt=0 -> done in 1 cycle, result=0, zeroFlag=1, carryFlag unchanged.
- start held high through a command -> exactly one command per acceptance; the second command is accepted one cycle after done. The checker confirms the two OE lines are never both low on any cycle.
